// File: rtl/operand_loader.sv
// -----------------------------------------------------------------------------
// operand_loader
//
// Serial-to-parallel operand front end for the compare stage. A framed,
// LSB-first bit stream carries operand A and then operand B. Both words are
// assembled in shift registers, and only a complete frame is copied to the
// registered a/b outputs, so the downstream combinational logic never sees
// partial operands.
//
// Optional feature: define PARITY_CHECK_EN to expect one even-parity bit
// after each operand. A parity failure pulses err for one cycle and drops
// the frame.
//
// Parameters:
//   W          operand width in bits (minimum 2)
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      frame start request, honoured only in IDLE
//   sin        serial data bit
//   sin_valid  sin is sampled on edges where this is high
//   out_ready  downstream accepts the held operands
//   a, b       assembled operands, registered
//   out_valid  a/b hold a fresh, unconsumed frame
//   busy       high in every state except IDLE
//   err        one-cycle parity-failure pulse (constant 0 without parity)
// -----------------------------------------------------------------------------
module operand_loader #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sin,
    input  logic         sin_valid,
    input  logic         out_ready,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic         out_valid,
    output logic         busy,
    output logic         err
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
`ifdef PARITY_CHECK_EN
        PAR_A  = 3'd2,
        PAR_B  = 3'd4,
`endif
        LOAD_B = 3'd3,
        HOLD   = 3'd5
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [W-1:0]  sha_reg, sha_next;
    logic [W-1:0]  shb_reg, shb_next;
    logic [W-1:0]  a_reg, a_next;
    logic [W-1:0]  b_reg, b_next;
    logic          out_valid_reg, out_valid_next;

    // Shifted versions of both registers with sin entering at the top, so
    // after W shifts the first bit received sits in bit 0.
    logic [W-1:0]  sha_shift;
    logic [W-1:0]  shb_shift;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_shift
            if (gi == W - 1) begin : g_top
                assign sha_shift[gi] = sin;
                assign shb_shift[gi] = sin;
            end else begin : g_low
                assign sha_shift[gi] = sha_reg[gi+1];
                assign shb_shift[gi] = shb_reg[gi+1];
            end
        end
    endgenerate

`ifdef PARITY_CHECK_EN
    logic err_reg, err_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            sha_reg       <= '0;
            shb_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            out_valid_reg <= 1'b0;
`ifdef PARITY_CHECK_EN
            err_reg       <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            sha_reg       <= sha_next;
            shb_reg       <= shb_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            out_valid_reg <= out_valid_next;
`ifdef PARITY_CHECK_EN
            err_reg       <= err_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        sha_next       = sha_reg;
        shb_next       = shb_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        out_valid_next = out_valid_reg;
`ifdef PARITY_CHECK_EN
        err_next       = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                // sin_valid in this cycle is deliberately not sampled
                if (start) begin
                    state_next = LOAD_A;
                    cnt_next   = '0;
                end
            end
            LOAD_A: begin
                if (sin_valid) begin
                    sha_next = sha_shift;
                    if (cnt_reg == LAST) begin
                        cnt_next = '0;
`ifdef PARITY_CHECK_EN
                        state_next = PAR_A;
`else
                        state_next = LOAD_B;
`endif
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            PAR_A: begin
                if (sin_valid) begin
                    if (^{sha_reg, sin}) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = LOAD_B;
                    end
                end
            end
`endif
            LOAD_B: begin
                if (sin_valid) begin
                    shb_next = shb_shift;
                    if (cnt_reg == LAST) begin
                        cnt_next = '0;
`ifdef PARITY_CHECK_EN
                        state_next = PAR_B;
`else
                        // Land the frame; B's last bit is still in flight,
                        // so take the shifted value rather than shb_reg.
                        state_next     = HOLD;
                        a_next         = sha_reg;
                        b_next         = shb_shift;
                        out_valid_next = 1'b1;
`endif
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            PAR_B: begin
                if (sin_valid) begin
                    if (^{shb_reg, sin}) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next     = HOLD;
                        a_next         = sha_reg;
                        b_next         = shb_reg;
                        out_valid_next = 1'b1;
                    end
                end
            end
`endif
            HOLD: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign a         = a_reg;
    assign b         = b_reg;
    assign out_valid = out_valid_reg;
    assign busy      = (state_reg != IDLE);
`ifdef PARITY_CHECK_EN
    assign err       = err_reg;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_operand_loader
//
// Directed bench for operand_loader (W=5). Inputs are driven 1 time unit
// after each rising edge and outputs are sampled at the same point, so every
// observation reflects the state registered by the preceding edge.
// Build with PARITY_CHECK_EN defined to exercise the parity frames.
// -----------------------------------------------------------------------------
module tb_operand_loader;

    localparam int W = 5;
`ifdef PARITY_CHECK_EN
    localparam int NB = 2 * W + 2;
`else
    localparam int NB = 2 * W;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sin;
    logic         sin_valid;
    logic         out_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         busy;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    operand_loader #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sin       (sin),
        .sin_valid (sin_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends start plus one frame, LSB first. gapped puts an idle cycle with
    // inverted garbage on sin before every bit. bad_pa corrupts A's parity
    // and stops after it, since the loader abandons the frame there.
    task automatic send_frame(input logic [W-1:0] av, input logic [W-1:0] bv,
                              input bit gapped, input bit bad_pa, output int ncyc);
        logic seq[$];
        seq = {};
        for (int i = 0; i < W; i++) seq.push_back(av[i]);
`ifdef PARITY_CHECK_EN
        seq.push_back((^av) ^ bad_pa);
`endif
        if (!bad_pa) begin
            for (int i = 0; i < W; i++) seq.push_back(bv[i]);
`ifdef PARITY_CHECK_EN
            seq.push_back(^bv);
`endif
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        ncyc = 0;
        for (int k = 0; k < seq.size(); k++) begin
            if (gapped) begin
                sin_valid = 1'b0;
                sin       = ~seq[k];
                tick();
                ncyc++;
            end
            if (k == seq.size() - 1) begin
                check("pre_last_out_valid", out_valid, 0);
                check("pre_last_busy", busy, 1);
            end
            sin_valid = 1'b1;
            sin       = seq[k];
            tick();
            ncyc++;
        end
        sin_valid = 1'b0;
        sin       = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hs_out_valid", out_valid, 0);
        check("hs_busy", busy, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        sin       = 1'b0;
        sin_valid = 1'b0;
        out_ready = 1'b0;
        #2;
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Contiguous frame a=22, b=5
        send_frame(5'd22, 5'd5, 1'b0, 1'b0, cyc);
        check("t1_out_valid", out_valid, 1);
        check("t1_a", a, 22);
        check("t1_b", b, 5);
        check("t1_busy", busy, 1);
        check("t1_latency", cyc, NB);
        handshake();
        check("t1_a_kept", a, 22);

        // Same frame with a gap before every bit
        send_frame(5'd22, 5'd5, 1'b1, 1'b0, cyc);
        check("t2_out_valid", out_valid, 1);
        check("t2_a", a, 22);
        check("t2_b", b, 5);
        check("t2_latency", cyc, 2 * NB);
        handshake();

        // Backpressure: 4 cycles without ready, start pulsed meanwhile
        send_frame(5'd9, 5'd18, 1'b0, 1'b0, cyc);
        for (int i = 0; i < 4; i++) begin
            start = (i == 1);
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_a", a, 9);
            check("bp_b", b, 18);
            check("bp_busy", busy, 1);
        end
        start = 1'b0;
        handshake();
        tick();
        check("bp_idle_after", busy, 0);

        // Asynchronous reset after 3 bits of a frame
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sin_valid = 1'b1;
            sin       = 1'b1;
            tick();
        end
        sin_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_a", a, 0);
        check("mid_rst_b", b, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        #2;
        rst_n = 1'b1;
        tick();
        send_frame(5'd0, 5'd31, 1'b0, 1'b0, cyc);
        check("post_rst_out_valid", out_valid, 1);
        check("post_rst_a", a, 0);
        check("post_rst_b", b, 31);
        handshake();

        // sin_valid together with start must not be captured
        sin_valid = 1'b1;
        sin       = 1'b1;
        send_frame(5'd6, 5'd17, 1'b0, 1'b0, cyc);
        check("stray_out_valid", out_valid, 1);
        check("stray_a", a, 6);
        check("stray_b", b, 17);
        handshake();
        check("no_err_clean", err, 0);

`ifdef PARITY_CHECK_EN
        // Wrong parity on A, then a correct frame
        send_frame(5'd7, 5'd0, 1'b0, 1'b1, cyc);
        check("par_err_pulse", err, 1);
        check("par_err_out_valid", out_valid, 0);
        check("par_err_busy", busy, 0);
        check("par_err_a_kept", a, 6);
        check("par_err_b_kept", b, 17);
        tick();
        check("par_err_one_cycle", err, 0);
        check("par_err_still_invalid", out_valid, 0);
        send_frame(5'd7, 5'd3, 1'b0, 1'b0, cyc);
        check("par_ok_out_valid", out_valid, 1);
        check("par_ok_a", a, 7);
        check("par_ok_b", b, 3);
        check("par_ok_err", err, 0);
        handshake();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
